// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single TCM data port between two requesters:
//   port 0 : core load/store unit
//   port 1 : loader / debug DMA master
//
// One request per cycle is forwarded downstream. The source of every accepted
// request is recorded in an in-order tracking FIFO, and each downstream ack is
// steered back to the port at the FIFO head.
//
// Handshake: a port request is valid when pN_rd_i or any pN_wr_i bit is set.
// The requester holds every request field stable until it sees pN_accept_o
// high in the same cycle. pN_ack_o is a one-cycle response strobe with no
// back-pressure; the response fields are meaningful only while it is high.
//
// Optional build macro:
//   DMEM_ARB_RR_EN  defined   -> round-robin on ties (port != last_grant)
//                   undefined -> fixed priority, port 0 wins ties
//
// Parameters:
//   OUTSTANDING  tracking FIFO depth, power of 2 in 2..16
//   TAG_W        request/response tag width
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   p0_*/p1_* request  (_i)           addr, data_wr, rd, wr strobes, req_tag
//   p0_*/p1_* response (_o)           accept, ack, error, data_rd, resp_tag
//   m_* request (_o)                  downstream addr, data_wr, rd, wr, req_tag
//   m_accept_i, m_ack_i, m_error_i    downstream handshake
//   m_data_rd_i, m_resp_tag_i         downstream response
//   spurious_o                        sticky: ack seen with tracking FIFO empty
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int TAG_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [31:0]      p0_addr_i,
  input  logic [31:0]      p0_data_wr_i,
  input  logic             p0_rd_i,
  input  logic [3:0]       p0_wr_i,
  input  logic [TAG_W-1:0] p0_req_tag_i,
  output logic             p0_accept_o,
  output logic             p0_ack_o,
  output logic             p0_error_o,
  output logic [31:0]      p0_data_rd_o,
  output logic [TAG_W-1:0] p0_resp_tag_o,

  input  logic [31:0]      p1_addr_i,
  input  logic [31:0]      p1_data_wr_i,
  input  logic             p1_rd_i,
  input  logic [3:0]       p1_wr_i,
  input  logic [TAG_W-1:0] p1_req_tag_i,
  output logic             p1_accept_o,
  output logic             p1_ack_o,
  output logic             p1_error_o,
  output logic [31:0]      p1_data_rd_o,
  output logic [TAG_W-1:0] p1_resp_tag_o,

  output logic [31:0]      m_addr_o,
  output logic [31:0]      m_data_wr_o,
  output logic             m_rd_o,
  output logic [3:0]       m_wr_o,
  output logic [TAG_W-1:0] m_req_tag_o,
  input  logic             m_accept_i,
  input  logic             m_ack_i,
  input  logic             m_error_i,
  input  logic [31:0]      m_data_rd_i,
  input  logic [TAG_W-1:0] m_resp_tag_i,

  output logic             spurious_o
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

  // Tracking state
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [OUTSTANDING-1:0] owner_fifo;   // one bit per slot: source port id
  logic                   lock;
  logic                   lock_id;
  logic                   spurious;
`ifdef DMEM_ARB_RR_EN
  logic                   last_grant;
`endif

  logic p0_valid;
  logic p1_valid;
  logic grant;
  logic grant_valid;
  logic slot_free;
  logic issue;
  logic accept;
  logic pop;
  logic head_owner;

  assign p0_valid = p0_rd_i | (|p0_wr_i);
  assign p1_valid = p1_rd_i | (|p1_wr_i);

  // Grant selection. A lock pins the grant to the port whose request was
  // presented but not yet taken, so a stalled request is never abandoned.
  always_comb begin
    grant = 1'b0;
    if (lock) begin
      grant = lock_id;
    end else if (p0_valid && p1_valid) begin
`ifdef DMEM_ARB_RR_EN
      grant = ~last_grant;
`else
      grant = 1'b0;
`endif
    end else begin
      grant = p1_valid;
    end
  end

  // Gating with rst_n keeps every strobe low while reset is asserted.
  assign grant_valid = rst_n & (grant ? p1_valid : p0_valid);
  // Full check uses the registered count only: a same-cycle pop does not
  // free a slot for a push.
  assign slot_free   = (count < FULL_CNT);
  assign issue       = grant_valid & slot_free;
  assign accept      = issue & m_accept_i;
  assign pop         = m_ack_i & (count != '0);
  assign head_owner  = owner_fifo[rd_ptr];

  // Downstream request mux; command strobes are suppressed when nothing may
  // be issued so the memory never sees a request we cannot track.
  assign m_addr_o    = grant ? p1_addr_i    : p0_addr_i;
  assign m_data_wr_o = grant ? p1_data_wr_i : p0_data_wr_i;
  assign m_req_tag_o = grant ? p1_req_tag_i : p0_req_tag_i;
  assign m_rd_o      = issue & (grant ? p1_rd_i : p0_rd_i);
  assign m_wr_o      = issue ? (grant ? p1_wr_i : p0_wr_i) : 4'b0000;

  assign p0_accept_o = accept & ~grant;
  assign p1_accept_o = accept &  grant;

  // Response steering: only the owner sees a non-zero response.
  assign p0_ack_o      = pop & ~head_owner;
  assign p1_ack_o      = pop &  head_owner;
  assign p0_error_o    = p0_ack_o & m_error_i;
  assign p1_error_o    = p1_ack_o & m_error_i;
  assign p0_data_rd_o  = p0_ack_o ? m_data_rd_i  : 32'h0;
  assign p1_data_rd_o  = p1_ack_o ? m_data_rd_i  : 32'h0;
  assign p0_resp_tag_o = p0_ack_o ? m_resp_tag_i : '0;
  assign p1_resp_tag_o = p1_ack_o ? m_resp_tag_i : '0;

  assign spurious_o = spurious;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      owner_fifo <= '0;
      lock       <= 1'b0;
      lock_id    <= 1'b0;
      spurious   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (accept) begin
        owner_fifo[wr_ptr] <= grant;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (m_ack_i && (count == '0)) begin
        spurious <= 1'b1;
      end
      // Lock is held exactly while the granted request is waiting; it also
      // drops if the owner withdraws, so a misbehaving requester cannot
      // wedge the other port.
      lock    <= grant_valid & ~accept;
      lock_id <= grant;
`ifdef DMEM_ARB_RR_EN
      if (accept) begin
        last_grant <= grant;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for dmem_port_arbiter. A small reference model predicts grant/accept
// per cycle from the driven inputs; each predicted accept pushes its source
// port into exp_q, and each downstream ack pops it to check response routing.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int OUTSTANDING = 4;
  localparam int TAG_W       = 11;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0]      p0_addr, p0_data_wr, p0_data_rd;
  logic             p0_rd, p0_accept, p0_ack, p0_error;
  logic [3:0]       p0_wr;
  logic [TAG_W-1:0] p0_req_tag, p0_resp_tag;
  logic [31:0]      p1_addr, p1_data_wr, p1_data_rd;
  logic             p1_rd, p1_accept, p1_ack, p1_error;
  logic [3:0]       p1_wr;
  logic [TAG_W-1:0] p1_req_tag, p1_resp_tag;
  logic [31:0]      m_addr, m_data_wr, m_data_rd;
  logic             m_rd, m_accept, m_ack, m_error;
  logic [3:0]       m_wr;
  logic [TAG_W-1:0] m_req_tag, m_resp_tag;
  logic             spurious;

  dmem_port_arbiter #(.OUTSTANDING(OUTSTANDING), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr_i(p0_addr), .p0_data_wr_i(p0_data_wr), .p0_rd_i(p0_rd),
    .p0_wr_i(p0_wr), .p0_req_tag_i(p0_req_tag), .p0_accept_o(p0_accept),
    .p0_ack_o(p0_ack), .p0_error_o(p0_error), .p0_data_rd_o(p0_data_rd),
    .p0_resp_tag_o(p0_resp_tag),
    .p1_addr_i(p1_addr), .p1_data_wr_i(p1_data_wr), .p1_rd_i(p1_rd),
    .p1_wr_i(p1_wr), .p1_req_tag_i(p1_req_tag), .p1_accept_o(p1_accept),
    .p1_ack_o(p1_ack), .p1_error_o(p1_error), .p1_data_rd_o(p1_data_rd),
    .p1_resp_tag_o(p1_resp_tag),
    .m_addr_o(m_addr), .m_data_wr_o(m_data_wr), .m_rd_o(m_rd), .m_wr_o(m_wr),
    .m_req_tag_o(m_req_tag), .m_accept_i(m_accept), .m_ack_i(m_ack),
    .m_error_i(m_error), .m_data_rd_i(m_data_rd), .m_resp_tag_i(m_resp_tag),
    .spurious_o(spurious)
  );

  // ---------------- scoreboard / model state ----------------
  logic [0:0] exp_q[$];
  logic       m_lock, m_lock_id, m_last, m_spur;
  logic       mdl_acc, mdl_g;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_p0(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [TAG_W-1:0] tag);
    p0_rd = rd; p0_wr = wr; p0_addr = addr; p0_req_tag = tag; p0_data_wr = ~addr;
  endtask

  task automatic set_p1(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [TAG_W-1:0] tag);
    p1_rd = rd; p1_wr = wr; p1_addr = addr; p1_req_tag = tag; p1_data_wr = addr ^ 32'h5A5A5A5A;
  endtask

  task automatic set_ack(input logic ack, input logic [31:0] data, input logic [TAG_W-1:0] tag,
                         input logic err);
    m_ack = ack; m_data_rd = data; m_resp_tag = tag; m_error = err;
  endtask

  // One clock: predict, check at negedge, advance model, return at posedge+1.
  task automatic cycle();
    logic v0, v1, g, gv, full, issue, acc, own;
    v0 = p0_rd | (|p0_wr);
    v1 = p1_rd | (|p1_wr);
    if (m_lock) g = m_lock_id;
    else if (v0 && v1) begin
`ifdef DMEM_ARB_RR_EN
      g = ~m_last;
`else
      g = 1'b0;
`endif
    end else g = v1;
    gv    = g ? v1 : v0;
    full  = (exp_q.size() >= OUTSTANDING);
    issue = gv && !full;
    acc   = issue && m_accept;
    @(negedge clk);
    check("p0_accept", 32'(p0_accept), 32'(acc && !g));
    check("p1_accept", 32'(p1_accept), 32'(acc && g));
    check("m_rd", 32'(m_rd), 32'(issue && (g ? p1_rd : p0_rd)));
    check("m_wr", 32'(m_wr), 32'(issue ? (g ? p1_wr : p0_wr) : 4'b0));
    if (issue) begin
      check("m_addr", m_addr, g ? p1_addr : p0_addr);
      check("m_data_wr", m_data_wr, g ? p1_data_wr : p0_data_wr);
      check("m_req_tag", 32'(m_req_tag), 32'(g ? p1_req_tag : p0_req_tag));
    end
    check("spurious", 32'(spurious), 32'(m_spur));
    if (m_ack && exp_q.size() > 0) begin
      own = exp_q.pop_front();
      check("p0_ack", 32'(p0_ack), 32'(!own));
      check("p1_ack", 32'(p1_ack), 32'(own));
      check("p0_data_rd", p0_data_rd, own ? 32'h0 : m_data_rd);
      check("p1_data_rd", p1_data_rd, own ? m_data_rd : 32'h0);
      check("p0_resp_tag", 32'(p0_resp_tag), own ? 32'h0 : 32'(m_resp_tag));
      check("p1_resp_tag", 32'(p1_resp_tag), own ? 32'(m_resp_tag) : 32'h0);
      check("p0_error", 32'(p0_error), 32'(!own && m_error));
      check("p1_error", 32'(p1_error), 32'(own && m_error));
    end else begin
      check("p0_ack_idle", 32'(p0_ack), 32'h0);
      check("p1_ack_idle", 32'(p1_ack), 32'h0);
      if (m_ack) m_spur = 1'b1;
    end
    if (acc) begin
      exp_q.push_back(g);
      m_last = g;
    end
    m_lock    = gv && !acc;
    m_lock_id = g;
    mdl_acc   = acc;
    mdl_g     = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    set_p0(1'b0, 4'h0, 32'h0, '0);
    set_p1(1'b0, 4'h0, 32'h0, '0);
    set_ack(1'b0, 32'h0, '0, 1'b0);
    m_accept = 1'b1;
  endtask

  // Reset with traffic asserted; every strobe must stay low during reset.
  task automatic do_reset();
    rst_n = 1'b0;
    set_p0(1'b1, 4'h0, 32'h1000, 11'h1);
    set_p1(1'b0, 4'hF, 32'h2000, 11'h2);
    set_ack(1'b1, 32'h1234, 11'h3, 1'b0);
    m_accept = 1'b1;
    @(negedge clk);
    check("rst_p0_accept", 32'(p0_accept), 32'h0);
    check("rst_p1_accept", 32'(p1_accept), 32'h0);
    check("rst_p0_ack", 32'(p0_ack), 32'h0);
    check("rst_p1_ack", 32'(p1_ack), 32'h0);
    check("rst_m_rd", 32'(m_rd), 32'h0);
    check("rst_m_wr", 32'(m_wr), 32'h0);
    check("rst_spurious", 32'(spurious), 32'h0);
    @(posedge clk);
    #1;
    idle_all();
    rst_n = 1'b1;
    exp_q.delete();
    m_lock = 1'b0; m_lock_id = 1'b0; m_last = 1'b1; m_spur = 1'b0;
  endtask

  task automatic drain();
    set_p0(1'b0, 4'h0, 32'h0, '0);
    set_p1(1'b0, 4'h0, 32'h0, '0);
    for (int k = 0; k < 2 * OUTSTANDING && exp_q.size() > 0; k++) begin
      set_ack(1'b1, $urandom, TAG_W'($urandom), 1'($urandom_range(0, 1)));
      cycle();
    end
    set_ack(1'b0, 32'h0, '0, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    do_reset();

    // Single read on port 0, ack two cycles later.
    set_p0(1'b1, 4'h0, 32'h80000010, 11'h05);
    cycle();
    set_p0(1'b0, 4'h0, 32'h0, '0);
    cycle();
    set_ack(1'b1, 32'hDEADBEEF, 11'h05, 1'b0);
    cycle();
    set_ack(1'b0, 32'h0, '0, 1'b0);

    // Both ports request every cycle; ack each cycle to keep slots free.
    set_p0(1'b1, 4'h0, 32'h100, 11'h10);
    set_p1(1'b0, 4'h3, 32'h200, 11'h20);
    for (int i = 0; i < 6; i++) begin
      set_ack(exp_q.size() > 0, 32'hA000 + i, TAG_W'(i), 1'b0);
      cycle();
    end
    set_ack(1'b0, 32'h0, '0, 1'b0);
    set_p0(1'b0, 4'h0, 32'h0, '0);
    cycle();
    drain();

    // Lock: p1 stalls three cycles while p0 joins; p1 goes first, then p0.
    set_p1(1'b0, 4'hF, 32'h300, 11'h31);
    m_accept = 1'b0;
    cycle();
    set_p0(1'b1, 4'h0, 32'h400, 11'h41);
    cycle();
    cycle();
    m_accept = 1'b1;
    cycle();
    set_p1(1'b0, 4'h0, 32'h0, '0);
    cycle();
    set_p0(1'b0, 4'h0, 32'h0, '0);
    drain();

    // Full: four accepts, fifth blocked, ack+request blocked, then accepted.
    for (int i = 0; i < OUTSTANDING + 1; i++) begin
      set_p0(1'b1, 4'h0, 32'h500 + 4 * i, TAG_W'(i));
      cycle();
    end
    set_ack(1'b1, 32'hB0, 11'h0, 1'b0);
    cycle();
    set_ack(1'b0, 32'h0, '0, 1'b0);
    cycle();
    drain();

    // Interleaved sources 0,1,1,0 then four acks tagged 1..4.
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 3) begin
        set_p0(1'b1, 4'h0, 32'h600 + i, TAG_W'(i + 1));
        set_p1(1'b0, 4'h0, 32'h0, '0);
      end else begin
        set_p0(1'b0, 4'h0, 32'h0, '0);
        set_p1(1'b1, 4'h0, 32'h700 + i, TAG_W'(i + 1));
      end
      cycle();
    end
    set_p0(1'b0, 4'h0, 32'h0, '0);
    set_p1(1'b0, 4'h0, 32'h0, '0);
    for (int i = 1; i <= 4; i++) begin
      set_ack(1'b1, 32'hC000 + i, TAG_W'(i), i == 3);
      cycle();
    end
    set_ack(1'b0, 32'h0, '0, 1'b0);

    // Randomised traffic respecting hold-until-accept.
    idle_all();
    for (int i = 0; i < 400; i++) begin
      if (!(p0_rd || |p0_wr) && $urandom_range(0, 2) == 0)
        set_p0(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, TAG_W'($urandom));
      if (!(p1_rd || |p1_wr) && $urandom_range(0, 2) == 0)
        set_p1(1'b1, 4'($urandom_range(0, 15)), $urandom, TAG_W'($urandom));
      m_accept = ($urandom_range(0, 3) != 0);
      set_ack(exp_q.size() > 0 && $urandom_range(0, 1) == 1, $urandom, TAG_W'($urandom),
              1'($urandom_range(0, 1)));
      cycle();
      if (mdl_acc && !mdl_g) set_p0(1'b0, 4'h0, 32'h0, '0);
      if (mdl_acc && mdl_g)  set_p1(1'b0, 4'h0, 32'h0, '0);
    end
    drain();

    // Spurious ack on empty FIFO; sticky until reset.
    idle_all();
    set_ack(1'b1, 32'hE0, 11'h7, 1'b0);
    cycle();
    set_ack(1'b0, 32'h0, '0, 1'b0);
    cycle();
    cycle();

    // Reset with two outstanding; later acks are spurious.
    do_reset();
    set_p0(1'b1, 4'h0, 32'h900, 11'h1);
    cycle();
    set_p0(1'b1, 4'h0, 32'h904, 11'h2);
    cycle();
    set_p0(1'b0, 4'h0, 32'h0, '0);
    do_reset();
    set_ack(1'b1, 32'hF1, 11'h1, 1'b0);
    cycle();
    set_ack(1'b1, 32'hF2, 11'h2, 1'b0);
    cycle();
    set_ack(1'b0, 32'h0, '0, 1'b0);
    cycle();
    check("spurious_after_reset", 32'(spurious), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single TCM data port (`mem_d_*` protocol) between two requesters: port 0, the core load/store unit, and port 1, a loader/debug DMA master. Forwards one request per cycle downstream, records the source of every accepted request in an in-order tracking FIFO, and steers each downstream ack back to its owner. Sits between `riscv_core` / loader and `tcm_mem` on the data side only; the instruction port is untouched.

## Interface
- `OUTSTANDING`, 4, tracking FIFO depth (power of 2, 2..16); max in-flight downstream requests
- `TAG_W`, 11, request/response tag width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pN_addr_i` (N=0,1)  in  32  request address
- `pN_data_wr_i`  in  32  write data
- `pN_rd_i`  in  1  read request
- `pN_wr_i`  in  4  byte write strobes
- `pN_req_tag_i`  in  TAG_W  request tag
- `pN_accept_o`  out  1  request taken this cycle
- `pN_ack_o`  out  1  response valid
- `pN_error_o`  out  1  response error
- `pN_data_rd_o`  out  32  read data
- `pN_resp_tag_o`  out  TAG_W  response tag
- `m_addr_o`, `m_data_wr_o`, `m_rd_o`, `m_wr_o[3:0]`, `m_req_tag_o`  out  downstream request (widths as above)
- `m_accept_i`, `m_ack_i`, `m_error_i`  in  1  downstream handshake
- `m_data_rd_i`  in  32, `m_resp_tag_i`  in  TAG_W  downstream response
- `spurious_o`  out  1  sticky: ack received with FIFO empty

## Operation
- Request valid: `pN_valid = pN_rd_i | (|pN_wr_i)`. Requesters hold request stable until `pN_accept_o`.
- Grant: if `lock` set, grant `lock_id`; else single requester wins; both requesting -> arbitration policy (see Configuration).
- Downstream request = granted port's fields, combinational mux; `m_rd_o`/`m_wr_o` forced 0 when no requester or `count == OUTSTANDING`.
- `pN_accept_o = grant==N & pN_valid & m_accept_i & (count < OUTSTANDING)`.
- Lock: granted valid request not accepted -> set `lock`, `lock_id`=grant next cycle; cleared on the cycle that request is accepted. No grant switch while locked.
- On accept: push grant id into FIFO (wr_ptr++, wrap mod OUTSTANDING).
- On `m_ack_i` with count>0: pop head; owner gets `pN_ack_o=1`, `pN_error_o=m_error_i`, `pN_data_rd_o=m_data_rd_i`, `pN_resp_tag_o=m_resp_tag_i`; non-owner outputs all 0.
- `m_ack_i` with count==0: no pop, no upstream ack, set `spurious_o` (cleared only by reset).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full check uses registered count; pop in same cycle does not free a slot for a push that cycle.

## Timing
- Request path and response path combinational: 0-cycle latency through the arbiter.
- Back-to-back accepts every cycle permitted while count < OUTSTANDING.
- Reset values: count=0, rd_ptr=wr_ptr=0, lock=0, last_grant=1 (port 0 wins first tie), `spurious_o`=0; all `pN_ack_o`, `pN_accept_o`, `m_rd_o`, `m_wr_o` 0 while in reset.
- Reset mid-operation: tracking state discarded; acks arriving after reset for pre-reset requests are spurious (set `spurious_o`).

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin; on tie grant the port ≠ `last_grant`; `last_grant` updated on every accept.
- Undefined: fixed priority, port 0 always wins ties; `last_grant` unused. Lock behaviour identical in both builds.

## Test plan
- Single read p0 addr 0x80000010, tag 0x05, m_accept_i=1, ack 2 cycles later with data 0xDEADBEEF -> p0_accept_o same cycle, p0_ack_o=1 with 0xDEADBEEF/tag 0x05, p1 outputs 0.
- Both ports request every cycle, m_accept_i=1 -> RR build: grants alternate 0,1,0,1 starting port 0; fixed build: port 1 starved until p0 drops.
- p1 granted alone, m_accept_i=0 for 3 cycles while p0 asserts -> grant stays p1 (lock), p1 accepted on 4th cycle, p0 next.
- OUTSTANDING=4, 4 accepts with no acks -> 5th request gets accept 0 and m_rd_o=0; ack+new request same cycle -> no accept that cycle, accept next cycle.
- Interleaved sources 0,1,1,0 then 4 acks with tags 1..4 -> acks delivered to p0,p1,p1,p0 in order.
- m_ack_i with empty FIFO -> no pN_ack_o, spurious_o=1 and stays 1 until rst_n low; reset with 2 outstanding then 2 acks -> spurious_o=1, no upstream acks.
